// File: rtl/mem_access_unit.sv
// Memory stage: serialises up to two slot memory ops onto one req/ack bus.
// Ports: in_* bundle from execute, dbus_* data bus, wb_* results to writeback.
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  slot_valid,
  input  logic [1:0]                  slot_load,
  input  logic [1:0]                  slot_store,
  input  logic [1:0][1:0]             slot_size,
  input  logic [1:0]                  slot_signed,
  input  logic [1:0][ADDR_W-1:0]      slot_addr,
  input  logic [1:0][DATA_W-1:0]      slot_wdata,
  input  logic [1:0][DATA_W-1:0]      slot_result,
  output logic                        dbus_req,
  output logic                        dbus_we,
  output logic [ADDR_W-1:0]           dbus_addr,
  output logic [3:0]                  dbus_be,
  output logic [DATA_W-1:0]           dbus_wdata,
  input  logic                        dbus_ack,
  input  logic [DATA_W-1:0]           dbus_rdata,
  output logic                        wb_valid,
  output logic [1:0]                  wb_slot_valid,
  output logic [1:0][DATA_W-1:0]      wb_data,
  output logic [1:0]                  exc_misaligned
);

  typedef enum logic [1:0] {IDLE, S0, S1, DONE} state_t;

  state_t state, state_n;

  logic [1:0]             ld_q;
  logic [1:0]             st_q;
  logic [1:0][1:0]        sz_q;
  logic [1:0]             sg_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][DATA_W-1:0] wd_q;
  logic [1:0][DATA_W-1:0] dat_q;
  logic [1:0][DATA_W-1:0] dat_n;
  logic                   need1_q;
  logic [1:0]             exc_q;
  logic [1:0]             cmt_q;

  logic [1:0] is_ld, is_st, mem_op, algn, mis;
  logic [1:0] need, exc_in, cmt_in;
  logic       accept;

  function automatic logic aligned(input logic [1:0] sz,
                                   input logic [1:0] a);
    unique case (sz)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~a[0];
      default: aligned = (a == 2'b00);
    endcase
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Classify the incoming bundle; a slot 0 fault kills slot 1.
  always_comb begin
    is_ld  = '0;
    is_st  = '0;
    mem_op = '0;
    algn   = '0;
    mis    = '0;
    for (int s = 0; s < 2; s++) begin
      is_ld[s]  = slot_load[s];
      is_st[s]  = slot_store[s] & ~slot_load[s];
      mem_op[s] = slot_valid[s] & (is_ld[s] | is_st[s]);
      algn[s]   = aligned(slot_size[s], slot_addr[s][1:0]);
      mis[s]    = mem_op[s] & ~algn[s];
    end
    exc_in[0] = mis[0];
    exc_in[1] = mis[1] & ~mis[0];
    need[0]   = mem_op[0] & algn[0];
    need[1]   = mem_op[1] & algn[1] & ~mis[0];
    cmt_in[0] = slot_valid[0] & ~mis[0];
    cmt_in[1] = slot_valid[1] & ~mis[1] & ~mis[0];
  end

  // Bus side is driven from the slot selected by the state.
  logic              cur;
  logic [1:0]        a;
  logic [1:0]        sz;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] lext;

  assign cur = (state == S1);
  assign a   = addr_q[cur][1:0];
  assign sz  = sz_q[cur];
  assign wd  = wd_q[cur];

  assign dbus_req  = (state == S0) || (state == S1);
  assign dbus_we   = st_q[cur];
  assign dbus_addr = {addr_q[cur][ADDR_W-1:2], 2'b00};

  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = wd;
    unique case (sz)
      2'd0: begin
        dbus_be    = 4'b0001 << a;
        dbus_wdata = {4{wd[7:0]}};
      end
      2'd1: begin
        dbus_be    = 4'b0011 << a;
        dbus_wdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh   = dbus_rdata >> {a, 3'b000};
    lext = sh;
    unique case (sz)
      2'd0: lext = {{(DATA_W-8){sg_q[cur] & sh[7]}}, sh[7:0]};
      2'd1: lext = {{(DATA_W-16){sg_q[cur] & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (accept)
          state_n = need[0] ? S0 : (need[1] ? S1 : DONE);
      S0:
        if (dbus_ack) state_n = need1_q ? S1 : DONE;
      S1:
        if (dbus_ack) state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Slot data: passthrough result, overwritten by load data on ack.
  always_comb begin
    dat_n = dat_q;
    if (accept) dat_n = slot_result;
    if (state == S0 && dbus_ack && ld_q[0]) dat_n[0] = lext;
    if (state == S1 && dbus_ack && ld_q[1]) dat_n[1] = lext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ld_q           <= '0;
      st_q           <= '0;
      sz_q           <= '0;
      sg_q           <= '0;
      addr_q         <= '0;
      wd_q           <= '0;
      dat_q          <= '0;
      need1_q        <= 1'b0;
      exc_q          <= '0;
      cmt_q          <= '0;
      wb_valid       <= 1'b0;
      wb_slot_valid  <= '0;
      wb_data        <= '0;
      exc_misaligned <= '0;
    end else begin
      state    <= state_n;
      dat_q    <= dat_n;
      wb_valid <= (state_n == DONE);
      if (accept) begin
        ld_q    <= is_ld;
        st_q    <= is_st;
        sz_q    <= slot_size;
        sg_q    <= slot_signed;
        addr_q  <= slot_addr;
        wd_q    <= slot_wdata;
        need1_q <= need[1];
        exc_q   <= exc_in;
        cmt_q   <= cmt_in;
      end
      if (state_n == DONE) begin
        wb_data        <= dat_n;
        wb_slot_valid  <= accept ? cmt_in : cmt_q;
        exc_misaligned <= accept ? exc_in : exc_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a byte-level memory model.
// Drives bundles, plays the bus with random wait states, checks writeback.
module tb_mem_access_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        slot_valid, slot_load, slot_store, slot_signed;
  logic [1:0][1:0]   slot_size;
  logic [1:0][31:0]  slot_addr, slot_wdata, slot_result;
  logic              dbus_req, dbus_we, dbus_ack;
  logic [31:0]       dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]        dbus_be;
  logic              wb_valid;
  logic [1:0]        wb_slot_valid, exc_misaligned;
  logic [1:0][31:0]  wb_data;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .slot_valid(slot_valid), .slot_load(slot_load),
    .slot_store(slot_store), .slot_size(slot_size),
    .slot_signed(slot_signed), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .slot_result(slot_result),
    .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .wb_valid(wb_valid),
    .wb_slot_valid(wb_slot_valid), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          w;
  } acc_t;

  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];

  logic [1:0]       b_v, b_ld, b_st, b_sg;
  logic [1:0][1:0]  b_sz;
  logic [1:0][31:0] b_addr, b_wd, b_res;
  int               fixed_wait = -1;
  bit               b2b = 0;

  task automatic put_inputs();
    slot_valid  = b_v;
    slot_load   = b_ld;
    slot_store  = b_st;
    slot_size   = b_sz;
    slot_signed = b_sg;
    slot_addr   = b_addr;
    slot_wdata  = b_wd;
    slot_result = b_res;
  endtask

  task automatic scramble();
    slot_valid  = 2'($urandom);
    slot_load   = 2'($urandom);
    slot_store  = 2'($urandom);
    slot_size   = 4'($urandom);
    slot_signed = 2'($urandom);
    slot_addr   = {$urandom, $urandom};
    slot_wdata  = {$urandom, $urandom};
    slot_result = {$urandom, $urandom};
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic run_bundle();
    logic [1:0]  ld, st, mo, al, mis, exc, cmt, acc;
    logic [31:0] exp_d [2];
    logic [31:0] v, base;
    acc_t        e, cur;
    acc_t        exp_q [$];
    int          n, lat, cyc, wl, off;
    bit          active;
    for (int s = 0; s < 2; s++) begin
      n      = nbytes(b_sz[s]);
      ld[s]  = b_ld[s];
      st[s]  = b_st[s] && !b_ld[s];
      mo[s]  = b_v[s] && (ld[s] || st[s]);
      al[s]  = (b_addr[s] % n) == 0;
      mis[s] = mo[s] && !al[s];
    end
    exc[0] = mis[0];
    exc[1] = !mis[0] && mis[1];
    acc[0] = mo[0] && al[0];
    acc[1] = mo[1] && al[1] && !mis[0];
    cmt[0] = b_v[0] && !mis[0];
    cmt[1] = b_v[1] && !mis[1] && !mis[0];
    lat = 1;
    for (int s = 0; s < 2; s++) begin
      exp_d[s] = b_res[s];
      if (acc[s]) begin
        n       = nbytes(b_sz[s]);
        off     = int'(b_addr[s] % 4);
        e.addr  = b_addr[s] & ~32'd3;
        e.we    = st[s];
        e.be    = '0;
        e.wdata = '0;
        for (int i = 0; i < n; i++) e.be[off + i] = 1'b1;
        for (int j = 0; j < 4; j++)
          e.wdata[8*j +: 8] = b_wd[s][8*(j % n) +: 8];
        e.w = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        lat += 1 + e.w;
        exp_q.push_back(e);
        if (st[s]) begin
          for (int i = 0; i < n; i++)
            ref_mem[(b_addr[s] + i) % 256] = b_wd[s][8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < n; i++)
            v[8*i +: 8] = ref_mem[(b_addr[s] + i) % 256];
          if (b_sg[s] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
          exp_d[s] = v;
        end
      end
    end

    put_inputs();
    in_valid = 1'b1;
    chk("ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = b2b;
    if (b2b) scramble();
    cyc = 1;
    active = 0;
    wl = 0;
    while (1) begin
      if (wb_valid) begin
        chk("latency", cyc, lat);
        chk("acc_left", exp_q.size() + int'(active), 0);
        chk("wb_slot_valid", wb_slot_valid, cmt);
        chk("exc", exc_misaligned, exc);
        for (int s = 0; s < 2; s++)
          if (cmt[s]) chk($sformatf("wb_data%0d", s), wb_data[s], exp_d[s]);
        break;
      end
      if (cyc >= 60) begin
        chk("timeout", cyc, lat);
        break;
      end
      chk("busy_ready", in_ready, 1'b0);
      if (dbus_req) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            chk("extra_req", dbus_req, 1'b0);
            dbus_ack = 1'b0;
          end else begin
            cur    = exp_q.pop_front();
            active = 1;
            wl     = cur.w;
          end
        end
        if (active) begin
          chk("addr", dbus_addr, cur.addr);
          chk("we", dbus_we, cur.we);
          chk("be", dbus_be, cur.be);
          if (cur.we) chk("wdata", dbus_wdata, cur.wdata);
          if (wl == 0) begin
            dbus_ack = 1'b1;
            base = dbus_addr % 256;
            for (int j = 0; j < 4; j++)
              dbus_rdata[8*j +: 8] = bus_mem[(base + j) % 256];
            if (dbus_we)
              for (int j = 0; j < 4; j++)
                if (dbus_be[j])
                  bus_mem[(base + j) % 256] = dbus_wdata[8*j +: 8];
            active = 0;
          end else begin
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
            wl--;
          end
        end
      end else begin
        dbus_ack   = 1'($urandom_range(0, 1));
        dbus_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (b2b) scramble();
    end
    dbus_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("wb_pulse", wb_valid, 1'b0);
    chk("ready_back", in_ready, 1'b1);
  endtask

  task automatic gen();
    int n;
    b_v  = 2'($urandom);
    b_ld = 2'($urandom);
    b_st = 2'($urandom);
    b_sz = 4'($urandom);
    b_sg = 2'($urandom);
    b_wd = {$urandom, $urandom};
    b_res = {$urandom, $urandom};
    for (int s = 0; s < 2; s++) begin
      n = nbytes(b_sz[s]);
      b_addr[s] = 32'h1000 + $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) b_addr[s] = b_addr[s] & ~(n - 1);
    end
    if ($urandom_range(0, 1) == 1) b_addr[1] = b_addr[0];
  endtask

  task automatic clear_bundle();
    b_v = '0; b_ld = '0; b_st = '0; b_sz = '0; b_sg = '0;
    b_addr = '0; b_wd = '0; b_res = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    rst = 1'b1;
    in_valid = 1'b0;
    dbus_ack = 1'b0;
    dbus_rdata = '0;
    clear_bundle();
    put_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_req", dbus_req, 1'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_wsv", wb_slot_valid, 2'b00);
    chk("rst_exc", exc_misaligned, 2'b00);
    chk("rst_wd0", wb_data[0], 32'h0);
    chk("rst_wd1", wb_data[1], 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // Reset in the middle of a waited load.
    b_v = 2'b01; b_ld = 2'b01; b_sz[0] = 2'd2; b_addr[0] = 32'h1000;
    put_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_req", dbus_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_hi_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_drop_req", dbus_req, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_lo_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("no_wb_after_rst", wb_valid, 1'b0);
    end

    // ALU-only bundle.
    clear_bundle();
    b_v = 2'b11; b_res[0] = 32'h11; b_res[1] = 32'h22;
    run_bundle();
    chk("alu_wd0", wb_data[0], 32'h11);
    chk("alu_wd1", wb_data[1], 32'h22);

    // sb then lb to the same byte, zero-wait.
    clear_bundle();
    fixed_wait = 0;
    b_v = 2'b11; b_st = 2'b01; b_ld = 2'b10; b_sg = 2'b10;
    b_addr[0] = 32'h1003; b_addr[1] = 32'h1003; b_wd[0] = 32'h1234_56AB;
    run_bundle();
    chk("sblb_wd1", wb_data[1], 32'hFFFF_FFAB);

    // lhu with three wait cycles.
    clear_bundle();
    fixed_wait = 3;
    bus_mem[2] = 8'h01; bus_mem[3] = 8'h80;
    ref_mem[2] = 8'h01; ref_mem[3] = 8'h80;
    b_v = 2'b01; b_ld = 2'b01; b_sz[0] = 2'd1; b_addr[0] = 32'h2002;
    run_bundle();
    chk("lhu_wd0", wb_data[0], 32'h0000_8001);

    // Misaligned lw in slot 0 suppresses store in slot 1.
    clear_bundle();
    fixed_wait = -1;
    b_v = 2'b11; b_ld = 2'b01; b_st = 2'b10;
    b_sz[0] = 2'd2; b_sz[1] = 2'd2;
    b_addr[0] = 32'h3002; b_addr[1] = 32'h3000;
    run_bundle();
    chk("mis0_exc", exc_misaligned, 2'b01);
    chk("mis0_wsv", wb_slot_valid, 2'b00);

    // Misaligned sh in slot 1, with in_valid held during the bundle.
    clear_bundle();
    b2b = 1;
    b_v = 2'b10; b_st = 2'b10; b_sz[1] = 2'd1; b_addr[1] = 32'h4001;
    run_bundle();
    chk("mis1_exc", exc_misaligned, 2'b10);

    for (int k = 0; k < 400; k++) begin
      b2b = 1'($urandom_range(0, 1));
      gen();
      run_bundle();
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage consumer of the two-slot request bundle the execute stage emits (per-slot result, load/store control, address, store data). It serialises up to two memory operations per bundle onto a single-ported data bus with a req/ack handshake, performs byte-lane alignment and load sign/zero extension, flags misaligned accesses, and presents both slot results to writeback together. It back-pressures execute with `in_ready` while a bundle is in flight.

## Interface
- `DATA_W`, 32: datapath and bus data width. Only 32 is supported.
- `ADDR_W`, 32: address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  bundle present from execute.
- `in_ready`  out  1  unit accepts a bundle this cycle.
- `slot_valid[1:0]`  in  2  per-slot instruction valid.
- `slot_load[1:0]`, `slot_store[1:0]`  in  2 each  per-slot memory op. Both set at once is illegal; load wins.
- `slot_size[1:0]`  in  2x2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- `slot_signed[1:0]`  in  2  sign-extend load data.
- `slot_addr[1:0]`  in  2xADDR_W  byte address.
- `slot_wdata[1:0]`  in  2xDATA_W  store data, right-aligned.
- `slot_result[1:0]`  in  2xDATA_W  execute result, passed through for non-load slots.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  write.
- `dbus_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `dbus_be`  out  4  byte enables.
- `dbus_wdata`  out  DATA_W  lane-replicated store data.
- `dbus_ack`  in  1  access complete; `dbus_rdata` is valid for reads in the ack cycle.
- `dbus_rdata`  in  DATA_W  read word.
- `wb_valid`  out  1  one-cycle pulse: the bundle is complete.
- `wb_slot_valid[1:0]`  out  2  slot committed (valid and not suppressed).
- `wb_data[1:0]`  out  2xDATA_W  load data or passthrough result.
- `exc_misaligned[1:0]`  out  2  slot raised an address-misaligned exception.

## Operation
- FSM states: IDLE, S0, S1, DONE.
- `in_ready` = (state == IDLE) && !rst.
- Handshake: `in_valid && in_ready` latches the whole bundle.
- A slot needs memory when it is valid, is a load or store, and is aligned.
  - Aligned means: half requires addr[0] = 0; word requires addr[1:0] = 0.
- Next state after accept:
  - S0 if slot 0 needs memory;
  - else S1 if slot 1 needs memory (and slot 0 did not fault);
  - else DONE.
- From S0 on ack: go to S1 if slot 1 needs memory, else DONE.
- From S1 on ack: go to DONE.
- From DONE: go to IDLE.
- Misaligned slot:
  - no bus access;
  - the slot's `exc_misaligned` bit is set;
  - its `wb_slot_valid` is 0.
- Precise ordering: a fault in slot 0 suppresses slot 1 entirely (no access, `wb_slot_valid[1]` = 0, `exc_misaligned[1]` = 0).
- `dbus_req` = 1 in S0/S1. `dbus_addr`, `dbus_we`, `dbus_be` and `dbus_wdata` are driven from the latched slot and held stable until ack.
- Byte enables, with a = addr[1:0]:
  - byte: `dbus_be` = 1 << a;
  - half: `dbus_be` = 4'b0011 << a;
  - word: `dbus_be` = 4'b1111.
  - Loads drive the same be.
- Store data:
  - byte: wdata[7:0] replicated ×4;
  - half: wdata[15:0] replicated ×2;
  - word: as-is.
- Load data: the selected lane is shifted to bit 0, then sign- or zero-extended per `slot_signed`. It is captured into `wb_data[s]` in the ack cycle.
- Non-load valid slots: `wb_data[s]` = `slot_result[s]`. Store slots also return `slot_result`.
- Slots are processed in order 0 then 1, so a store in slot 0 is visible to a load in slot 1 at the same address.

## Timing
- Reset:
  - state = IDLE;
  - `dbus_req`, `wb_valid`, `wb_slot_valid`, `exc_misaligned` = 0;
  - `wb_data` = 0;
  - `in_ready` = 0 while `rst` is high and 1 the cycle after it drops.
- Reset mid-access: `dbus_req` drops in the cycle after the reset edge. The bundle is discarded and `wb_valid` is not produced.
- `dbus_ack` is ignored unless `dbus_req` = 1. An ack in the first request cycle is legal (zero-wait, one cycle per access).
- Latency from the accept edge to `wb_valid`, with k = number of bus accesses and w_i = wait cycles of access i:
  - no access: 1 cycle;
  - otherwise: 1 + Σ(1 + w_i) cycles.
- `wb_*` outputs are registered and valid only while `wb_valid` = 1. They are held until the next bundle's DONE.
- Throughput: one bundle per (latency + 1) cycles. No new bundle is accepted in DONE.

## Test plan
- Reset with `dbus_req` high mid-wait → `dbus_req` = 0 the next cycle, `wb_valid` never pulses, `in_ready` = 1 after `rst` falls.
- ALU-only bundle (results 0x11, 0x22, no mem ops) → no `dbus_req`, `wb_valid` the cycle after accept, `wb_data` = {0x22, 0x11}, `wb_slot_valid` = 2'b11.
- Slot 0: sb addr 0x1003, wdata 0xAB; slot 1: lb signed addr 0x1003; zero-wait bus model → first access addr 0x1000, be 4'b1000, wdata 0xABABABAB; second access returns 0xAB000000; `wb_data[1]` = 0xFFFFFFAB; `wb_valid` at 3 cycles after accept.
- Slot 0 lhu addr 0x2002 with 3 wait cycles, rdata 0x8001_0000 → be 4'b1100, signals stable for 4 cycles, `wb_data[0]` = 0x00008001.
- Slot 0 lw addr 0x3002 (misaligned), slot 1 valid sw → no bus access, `exc_misaligned` = 2'b01, `wb_slot_valid` = 2'b00, `wb_valid` 1 cycle after accept.
- Slot 0 invalid, slot 1 sh addr 0x4001 → `exc_misaligned` = 2'b10, no access. Then back-to-back `in_valid` → second bundle accepted only when `in_ready` returns in IDLE.
